// File: rtl/key_matrix_scanner.sv
// 4x4 key matrix scanner: column drive, 2-flop row sync, per-key debounce, CPU KIN port.
// Samples one column per DEB_TICK clocks; a key flips after DEB_COUNT consecutive disagreeing samples.
module key_matrix_scanner #(
  parameter int DEB_TICK  = 256,
  parameter int DEB_COUNT = 4
) (
  input  logic        clk_in,
  input  logic        RESET,
  input  logic        ena,
  input  logic [3:0]  row_in_n,
  output logic [3:0]  col_n,
  input  logic [3:0]  nL,
  output logic [3:0]  KIN,
  output logic [15:0] key_state,
  output logic        key_event,
  output logic [3:0]  key_code,
  output logic        key_dir
);

  localparam logic [15:0] TICK_LAST = 16'(DEB_TICK - 1);
  localparam logic [2:0]  CNT_LIM   = 3'(DEB_COUNT);

  logic [3:0]  sync1_q, sync2_q;
  logic [3:0]  row_s;
  logic [15:0] presc_q, presc_d;
  logic [1:0]  col_q, col_d;
  logic        tick;

  logic [2:0]  cnt_q [16];
  logic [2:0]  cnt_d [16];
  logic [15:0] state_q, state_d;
  logic        event_q, event_d;
  logic [3:0]  code_q, code_d;
  logic        dir_q, dir_d;

  logic        flip_found;
  logic [3:0]  idx;
  logic [2:0]  cnt_inc;

  // Synchronizer stores the inverted (active-high) row so reset reads as "no key"
  always_ff @(posedge clk_in or negedge RESET) begin
    if (!RESET) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= ~row_in_n;
      sync2_q <= sync1_q;
    end
  end

  assign row_s = sync2_q;

  always_comb begin
    tick    = ena && (presc_q == TICK_LAST);
    presc_d = presc_q;
    col_d   = col_q;
    if (ena) begin
      if (tick) begin
        presc_d = '0;
        col_d   = col_q + 2'd1;
      end else begin
        presc_d = presc_q + 16'd1;
      end
    end
  end

  // Rows are visited low to high, so the first flip seen is the lowest key index
  always_comb begin
    cnt_d      = cnt_q;
    state_d    = state_q;
    event_d    = 1'b0;
    code_d     = code_q;
    dir_d      = dir_q;
    flip_found = 1'b0;
    idx        = '0;
    cnt_inc    = '0;
    if (tick) begin
      for (int r = 0; r < 4; r++) begin
        idx     = {2'(r), col_q};
        cnt_inc = cnt_q[idx] + 3'd1;
        if (row_s[idx[3:2]] == state_q[idx]) begin
          cnt_d[idx] = '0;
        end else if (cnt_inc == CNT_LIM) begin
          cnt_d[idx]   = '0;
          state_d[idx] = ~state_q[idx];
          if (!flip_found) begin
            flip_found = 1'b1;
            event_d    = 1'b1;
            code_d     = idx;
            dir_d      = ~state_q[idx];
          end
        end else begin
          cnt_d[idx] = cnt_inc;
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge RESET) begin
    if (!RESET) begin
      presc_q <= '0;
      col_q   <= '0;
      cnt_q   <= '{default: '0};
      state_q <= '0;
      event_q <= 1'b0;
      code_q  <= '0;
      dir_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      col_q   <= col_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      event_q <= event_d;
      code_q  <= code_d;
      dir_q   <= dir_d;
    end
  end

  assign col_n = ~(4'b0001 << col_q);

  // KIN is a wired-OR of every CPU-selected column of debounced state
  for (genvar r = 0; r < 4; r++) begin : g_kin
    assign KIN[r] = |(state_q[r*4 +: 4] & ~nL);
  end

  assign key_state = state_q;
  assign key_event = event_q;
  assign key_code  = code_q;
  assign key_dir   = dir_q;

endmodule

// File: tb/tb_key_matrix_scanner.sv
// Bench for key_matrix_scanner: physical matrix model, high-level debounce reference, scenario tasks.
module tb_key_matrix_scanner;

  localparam int T = 4;
  localparam int C = 2;

  logic        clk_in = 1'b0;
  logic        RESET  = 1'b0;
  logic        ena    = 1'b0;
  logic [3:0]  row_in_n;
  logic [3:0]  col_n;
  logic [3:0]  nL = 4'hF;
  logic [3:0]  KIN;
  logic [15:0] key_state;
  logic        key_event;
  logic [3:0]  key_code;
  logic        key_dir;

  logic [15:0] phys = '0;
  int total = 0;
  int bad   = 0;

  always #5 clk_in = ~clk_in;

  // A held key shorts its row low only while its column is driven low
  always_comb begin
    row_in_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (phys[r*4+c] && !col_n[c]) row_in_n[r] = 1'b0;
  end

  key_matrix_scanner #(.DEB_TICK(T), .DEB_COUNT(C)) dut (
    .clk_in(clk_in), .RESET(RESET), .ena(ena), .row_in_n(row_in_n), .col_n(col_n),
    .nL(nL), .KIN(KIN), .key_state(key_state), .key_event(key_event),
    .key_code(key_code), .key_dir(key_dir)
  );

  // Reference: count enabled clocks; every T-th is a tick on column (ticks-1)%4,
  // which sees the key matrix as it stood two clocks earlier.
  int          m_en = 0;
  logic [15:0] m_state = '0, m_ph0 = '0, m_ph1 = '0, m_smp = '0;
  int          m_cnt [16];
  logic        m_evt = 1'b0;
  logic [3:0]  m_code = '0;
  logic        m_dir = 1'b0;
  logic [3:0]  m_coln = 4'b1110;

  initial begin
    int mc, mk;
    bit found;
    foreach (m_cnt[i]) m_cnt[i] = 0;
    forever begin
      @(posedge clk_in or negedge RESET);
      if (!RESET) begin
        m_en = 0; m_state = '0; m_ph0 = '0; m_ph1 = '0;
        foreach (m_cnt[i]) m_cnt[i] = 0;
        m_evt = 1'b0; m_code = '0; m_dir = 1'b0; m_coln = 4'b1110;
      end else begin
        m_smp = m_ph1; m_ph1 = m_ph0; m_ph0 = phys;
        m_evt = 1'b0;
        if (ena) begin
          m_en++;
          if (m_en % T == 0) begin
            mc = (m_en / T - 1) % 4;
            found = 0;
            for (int r = 0; r < 4; r++) begin
              mk = r * 4 + mc;
              if (m_smp[mk] == m_state[mk]) m_cnt[mk] = 0;
              else begin
                m_cnt[mk]++;
                if (m_cnt[mk] == C) begin
                  m_cnt[mk] = 0;
                  m_state[mk] = !m_state[mk];
                  if (!found) begin
                    found = 1; m_evt = 1'b1; m_code = 4'(mk); m_dir = m_state[mk];
                  end
                end
              end
            end
          end
          m_coln = ~(4'b0001 << ((m_en / T) % 4));
        end
      end
    end
  end

  function automatic logic [3:0] model_kin(input logic [15:0] st, input logic [3:0] sel);
    logic [3:0] v = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (st[r*4+c] && !sel[c]) v[r] = 1'b1;
    return v;
  endfunction

  task automatic do_reset(input logic [15:0] keys);
    @(negedge clk_in);
    RESET = 1'b0; ena = 1'b1; nL = 4'hF; phys = keys;
    repeat (2) @(negedge clk_in);
    RESET = 1'b1;
  endtask

  task automatic test_reset();
    logic [3:0] tbl [4];
    tbl[0] = 4'b1110; tbl[1] = 4'b1101; tbl[2] = 4'b1011; tbl[3] = 4'b0111;
    do_reset(16'h0000);
    total++;
    if ({col_n, KIN, key_state, key_event, key_code, key_dir} !== {4'b1110, 4'b0, 16'b0, 1'b0, 4'b0, 1'b0}) begin
      bad++; $display("FAIL reset_vals got %h want %h", {col_n, KIN, key_state, key_event, key_code, key_dir}, {4'b1110, 26'b0});
    end
    nL = 4'b0000; #1;
    total++;
    if (KIN !== 4'b0000) begin bad++; $display("FAIL reset_kin got %b want 0000", KIN); end
    nL = 4'hF;
    for (int n = 1; n <= 17; n++) begin
      @(negedge clk_in);
      total++;
      if (col_n !== tbl[(n / 4) % 4]) begin
        bad++; $display("FAIL reset_coln n=%0d got %b want %b", n, col_n, tbl[(n / 4) % 4]);
      end
    end
  endtask

  task automatic test_stable_press();
    int evts = 0;
    do_reset(16'h0040);
    for (int n = 1; n <= 32; n++) begin
      @(negedge clk_in);
      if (key_event) evts++;
      total++;
      if ({key_state, key_event, key_code, key_dir, col_n} !== {m_state, m_evt, m_code, m_dir, m_coln}) begin
        bad++; $display("FAIL press_model n=%0d got %h want %h", n, {key_state, key_event, key_code, key_dir, col_n}, {m_state, m_evt, m_code, m_dir, m_coln});
      end
      if (n == 27) begin
        total++;
        if (key_state !== 16'h0000) begin bad++; $display("FAIL press_early got %h want 0000", key_state); end
      end
      if (n == 28) begin
        total++;
        if ({key_state, key_event, key_code, key_dir} !== {16'h0040, 1'b1, 4'd6, 1'b1}) begin
          bad++; $display("FAIL press_flip got %h want %h", {key_state, key_event, key_code, key_dir}, {16'h0040, 1'b1, 4'd6, 1'b1});
        end
      end
    end
    total++;
    if (evts != 1) begin bad++; $display("FAIL press_evt_count got %0d want 1", evts); end
    nL = 4'b1011; #1;
    total++;
    if (KIN !== 4'b0010) begin bad++; $display("FAIL press_kin_col2 got %b want 0010", KIN); end
    nL = 4'b1110; #1;
    total++;
    if (KIN !== 4'b0000) begin bad++; $display("FAIL press_kin_col0 got %b want 0000", KIN); end
    nL = 4'b0000; #1;
    total++;
    if (KIN !== 4'b0010) begin bad++; $display("FAIL press_kin_all got %b want 0010", KIN); end
    nL = 4'hF;
  endtask

  task automatic test_bounce();
    int evts = 0;
    do_reset(16'h0000);
    for (int n = 1; n <= 50; n++) begin
      @(negedge clk_in);
      if (key_event) evts++;
      total++;
      if ({key_state, key_event, key_code, key_dir, col_n} !== {m_state, m_evt, m_code, m_dir, m_coln}) begin
        bad++; $display("FAIL bounce_model n=%0d got %h want %h", n, {key_state, key_event, key_code, key_dir, col_n}, {m_state, m_evt, m_code, m_dir, m_coln});
      end
      if (n == 8)  phys = 16'h0040;
      if (n == 14) phys = 16'h0000;
    end
    total++;
    if (key_state !== 16'h0000 || evts != 0) begin
      bad++; $display("FAIL bounce_reject state=%h evts=%0d want 0000/0", key_state, evts);
    end
  endtask

  task automatic test_release_simul();
    int evts = 0;
    do_reset(16'h0202);
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk_in);
      if (key_event && n > 24) evts++;
      total++;
      if ({key_state, key_event, key_code, key_dir, col_n} !== {m_state, m_evt, m_code, m_dir, m_coln}) begin
        bad++; $display("FAIL simul_model n=%0d got %h want %h", n, {key_state, key_event, key_code, key_dir, col_n}, {m_state, m_evt, m_code, m_dir, m_coln});
      end
      if (n == 24) begin
        total++;
        if ({key_state, key_event, key_code, key_dir} !== {16'h0202, 1'b1, 4'd1, 1'b1}) begin
          bad++; $display("FAIL simul_press got %h want %h", {key_state, key_event, key_code, key_dir}, {16'h0202, 1'b1, 4'd1, 1'b1});
        end
      end
      if (n == 56) begin
        total++;
        if ({key_state, key_event, key_code, key_dir} !== {16'h0000, 1'b1, 4'd1, 1'b0}) begin
          bad++; $display("FAIL simul_release got %h want %h", {key_state, key_event, key_code, key_dir}, {16'h0000, 1'b1, 4'd1, 1'b0});
        end
      end
      if (n == 30) phys = 16'h0000;
    end
    total++;
    if (evts != 1) begin bad++; $display("FAIL simul_evt_count got %0d want 1", evts); end
  endtask

  task automatic test_enable();
    do_reset(16'h0040);
    for (int n = 1; n <= 44; n++) begin
      @(negedge clk_in);
      total++;
      if ({key_state, key_event, key_code, key_dir, col_n} !== {m_state, m_evt, m_code, m_dir, m_coln}) begin
        bad++; $display("FAIL ena_model n=%0d got %h want %h", n, {key_state, key_event, key_code, key_dir, col_n}, {m_state, m_evt, m_code, m_dir, m_coln});
      end
      if (n == 25) begin
        total++;
        if (col_n !== 4'b0111) begin bad++; $display("FAIL ena_hold_col got %b want 0111", col_n); end
      end
      if (n == 26) begin
        total++;
        if (col_n !== 4'b1110) begin bad++; $display("FAIL ena_shift_col got %b want 1110", col_n); end
      end
      if (n == 37) begin
        total++;
        if (key_state !== 16'h0000) begin bad++; $display("FAIL ena_early got %h want 0000", key_state); end
      end
      if (n == 38) begin
        total++;
        if ({key_state, key_event} !== {16'h0040, 1'b1}) begin
          bad++; $display("FAIL ena_flip got %h want %h", {key_state, key_event}, {16'h0040, 1'b1});
        end
      end
      if (n == 40) begin
        ena = 1'b0; nL = 4'b1011; #1;
        total++;
        if (KIN !== 4'b0010) begin bad++; $display("FAIL ena_kin_live got %b want 0010", KIN); end
        nL = 4'hF;
      end
      if (n == 14) ena = 1'b0;
      if (n == 24 || n == 41) ena = 1'b1;
    end
  endtask

  task automatic test_reset_mid();
    do_reset(16'h0042);
    repeat (25) @(negedge clk_in);
    total++;
    if ({key_state, key_code, key_dir, col_n} !== {16'h0002, 4'd1, 1'b1, 4'b1011}) begin
      bad++; $display("FAIL rmid_before got %h want %h", {key_state, key_code, key_dir, col_n}, {16'h0002, 4'd1, 1'b1, 4'b1011});
    end
    RESET = 1'b0; phys = 16'h0040; #1;
    total++;
    if ({col_n, key_state, key_event, key_code, key_dir} !== {4'b1110, 16'h0000, 1'b0, 4'd0, 1'b0}) begin
      bad++; $display("FAIL rmid_async got %h want %h", {col_n, key_state, key_event, key_code, key_dir}, {4'b1110, 22'b0});
    end
    nL = 4'b0000; #1;
    total++;
    if (KIN !== 4'b0000) begin bad++; $display("FAIL rmid_kin got %b want 0000", KIN); end
    nL = 4'hF;
    @(negedge clk_in);
    RESET = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk_in);
      total++;
      if ({key_state, key_event, key_code, key_dir, col_n} !== {m_state, m_evt, m_code, m_dir, m_coln}) begin
        bad++; $display("FAIL rmid_model n=%0d got %h want %h", n, {key_state, key_event, key_code, key_dir, col_n}, {m_state, m_evt, m_code, m_dir, m_coln});
      end
      if (n == 27) begin
        total++;
        if (key_state !== 16'h0000) begin bad++; $display("FAIL rmid_early got %h want 0000", key_state); end
      end
      if (n == 28) begin
        total++;
        if ({key_state, key_event, key_code, key_dir} !== {16'h0040, 1'b1, 4'd6, 1'b1}) begin
          bad++; $display("FAIL rmid_flip got %h want %h", {key_state, key_event, key_code, key_dir}, {16'h0040, 1'b1, 4'd6, 1'b1});
        end
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] want_kin;
    do_reset(16'h0000);
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk_in);
      total++;
      if ({key_state, key_event, key_code, key_dir, col_n} !== {m_state, m_evt, m_code, m_dir, m_coln}) begin
        bad++; $display("FAIL rand_model i=%0d got %h want %h", i, {key_state, key_event, key_code, key_dir, col_n}, {m_state, m_evt, m_code, m_dir, m_coln});
      end
      if ($urandom_range(0, 9) == 0) phys = phys ^ (16'h0001 << $urandom_range(0, 15));
      ena = ($urandom_range(0, 7) != 0);
      nL  = 4'($urandom);
      #1;
      want_kin = model_kin(m_state, nL);
      total++;
      if (KIN !== want_kin) begin
        bad++; $display("FAIL rand_kin i=%0d nL=%b got %b want %b", i, nL, KIN, want_kin);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stable_press();
    test_bounce();
    test_release_simul();
    test_enable();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
